uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Stand-alone UART receiver: the far end of the link driven by the UART core's TX pin.
//   - Samples a serial line at 16x oversampling, with 3-sample majority vote at mid-bit.
//   - Frame format: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
//   - Each frame plus its error flags is pushed into a small FWFT FIFO, drained by valid/ready.
//   - Sits on the chip's serial input, alongside the existing UART core, sharing its cfg/clk16 conventions.
// PARAMETERS
//   DEPTH        4   FIFO entries; power of two, >=2
//   SYNC_STAGES  2   flops in the rx input synchronizer; >=2
// PORTS
//   clk         in   1   system clock
//   rst         in   1   reset, asynchronous, active-high
//   clk16       in   1   one-clk enable pulse at 16x baud; all bit timing advances only on it
//   cfg         in   5   [1:0] data bits = 5+cfg[1:0]; [2] 1=even parity; [3] parity enable; [4] 1=two stop bits
//   rx          in   1   asynchronous serial line, idle high
//   out_data    out  8   head-of-FIFO data, right-aligned, unused MSBs zero
//   out_perr    out  1   head entry parity error
//   out_ferr    out  1   head entry framing error (stop bit sampled 0)
//   out_valid   out  1   FIFO not empty
//   out_ready   in   1   pop head when out_valid&out_ready
//   fifo_count  out  clog2(DEPTH)+1  entries held
//   overrun     out  1   sticky: a completed frame was dropped because the FIFO was full
//   ovr_clr     in   1   one-clk pulse, clears overrun
//   busy        out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset:
//   - synchronizer flops=1; FSM=IDLE; FIFO empty; all outputs 0 (out_data=0, fifo_count=0).
//   FSM:
//   - States: IDLE, START, DATA, PARITY, STOP. Tick counter cnt 0..15 per bit, advances on clk16 only.
//   - On each bit, samples are taken at cnt 7,8,9. The bit value (majority of 2 of 3) is decided at cnt==9.
//   - The FSM moves to the next bit after cnt==15.
//   - IDLE: on clk16 with synced rx==0 -> START, cnt=1; cfg is latched here. cfg changes mid-frame are ignored.
//   - START: majority==1 at cnt 9 -> false start, back to IDLE, nothing pushed. Else at cnt 15 -> DATA.
//   - DATA: LSB first, N=5+cfg[1:0] bits; after bit N -> PARITY if enabled, else STOP.
//   - PARITY: expected bit = even ? ^data : ~^data; mismatch sets frame perr.
//   - STOP: each stop bit sampled 0 sets frame ferr. With cfg[4]=1, two stop bits are checked.
//   - Frame completes at cnt==9 of the last stop bit. The push happens on that cycle, then -> IDLE.
//     A stop bit of 0 therefore cannot be re-detected as a start until rx returns high.
//   - Latency: push occurs 1 clk after the cnt==9 tick of the last stop bit. out_valid rises the same cycle.
//   FIFO:
//   - Entry = {ferr, perr, data[7:0]}; first-word fall-through, so outputs show the head while not empty.
//   - Pop when out_valid&out_ready; a pop with out_valid=0 is ignored.
//   - Push while full with no pop in the same cycle: frame dropped, overrun<=1, FIFO contents unchanged.
//   - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
//   - Push and pop in the same cycle when empty: the push lands, the pop is ignored (out_valid was 0).
//   - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//   - overrun set and ovr_clr in the same cycle: set wins.
//   Reset:
//   - Reset mid-frame aborts the frame, nothing is pushed, and the FIFO is flushed.
// TESTING
//   1. 8N1 (cfg=5'b00011), send 0xA5 -> one entry data=0xA5, perr=0, ferr=0, fifo_count=1.
//   2. 5-bit even parity (cfg=5'b01100), send 0x13 with parity bit 0 (wrong) -> data=0x13, perr=1.
//   3. rx low for 4 clk16 ticks then high -> FSM returns to IDLE, fifo_count stays 0, busy drops.
//   4. 8N2, send 0x3C with second stop bit 0 -> data=0x3C, ferr=1. The next frame 0x55 is still received correctly.
//   5. DEPTH=4, out_ready=0, send 5 frames 0x01..0x05 -> count=4, overrun=1.
//      Pops then return 0x01..0x04; ovr_clr clears overrun.
//   6. Assert rst during DATA of frame 0x77, release, send 0x42 -> only 0x42 is received, no error flags.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a first-word-fall-through FIFO drained by valid/ready.
// Entry lands 1 clk after mid-point of the last stop bit; a full FIFO with no pop drops the frame and sets overrun.
module uart_rx_fifo #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk16,
    input  logic [4:0]               cfg,
    input  logic                     rx,
    output logic [7:0]               out_data,
    output logic                     out_perr,
    output logic                     out_ferr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  cfg_q, cfg_d;
    logic [1:0]  smp_q, smp_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        stop2_q, stop2_d;
    logic        armed_q, armed_d;
    logic        maj, par_exp, push;
    logic [9:0]  push_dat;

    // Samples from cnt 7 and 8 are held; the third is the live line at cnt 9.
    assign maj     = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
    assign par_exp = cfg_q[2] ? ^data_q : ~^data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            cfg_q   <= '0;
            smp_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            stop2_q <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            smp_q   <= smp_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            stop2_q <= stop2_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        cfg_d    = cfg_q;
        smp_d    = smp_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        stop2_d  = stop2_q;
        armed_d  = armed_q;
        push     = 1'b0;
        push_dat = {ferr_q | ~maj, perr_q, data_q};

        // After a low stop bit the line must go high again before a new start is accepted.
        if (state_q == IDLE && rx_s)
            armed_d = 1'b1;

        if (clk16) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) smp_d[0] = rx_s;
            if (cnt_q == 4'd8) smp_d[1] = rx_s;
            case (state_q)
                IDLE: begin
                    cnt_d = cnt_q;
                    if (!rx_s && armed_q) begin
                        state_d = START;
                        cnt_d   = 4'd1;
                        cfg_d   = cfg;
                        data_d  = '0;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        stop2_d = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == 4'd9 && maj)  state_d = IDLE;
                    else if (cnt_q == 4'd15)   state_d = DATA;
                end
                DATA: begin
                    if (cnt_q == 4'd9) data_d[bit_q] = maj;
                    if (cnt_q == 4'd15) begin
                        if (bit_q == {1'b1, cfg_q[1:0]})
                            state_d = cfg_q[3] ? PARITY : STOP;
                        else
                            bit_d = bit_q + 3'd1;
                    end
                end
                PARITY: begin
                    if (cnt_q == 4'd9 && maj != par_exp) perr_d = 1'b1;
                    if (cnt_q == 4'd15)                  state_d = STOP;
                end
                STOP: begin
                    if (cnt_q == 4'd9) begin
                        if (!maj) ferr_d = 1'b1;
                        if (!(cfg_q[4] && !stop2_q)) begin
                            push    = 1'b1;
                            state_d = IDLE;
                            armed_d = maj;
                        end
                    end
                    if (cnt_q == 4'd15) stop2_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic          full, pop, wr_en;

    assign full      = (fifo_count == (AW+1)'(DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            else if (ovr_clr)         overrun <= 1'b0;
        end
    end

    assign out_data = out_valid ? mem[rd_q][7:0] : 8'h00;
    assign out_perr = out_valid & mem[rd_q][8];
    assign out_ferr = out_valid & mem[rd_q][9];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Random and directed UART frames checked against a queue model of the received-frame FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clk16 = 1'b0;
    logic [4:0]             cfg = 5'b00011;
    logic                   rx = 1'b1;
    logic                   out_ready = 1'b0;
    logic                   ovr_clr = 1'b0;
    logic [7:0]             out_data;
    logic                   out_perr, out_ferr, out_valid, overrun, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .clk16(clk16), .cfg(cfg), .rx(rx),
        .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] q[$];
    bit m_ovr = 0;
    bit pending = 0;
    bit force_rdy = 0;
    bit rand_en = 0;

    always #5 clk = ~clk;

    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            clk16 = (div == 3);
            div = (div + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = !pending && (force_rdy || (rand_en && ($urandom_range(0, 3) == 0)));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!pending && !rst) begin
            check("valid", out_valid, q.size() != 0);
            check("count", fifo_count, q.size());
            check("overrun", overrun, m_ovr);
            if (q.size() != 0)
                check("head", {out_ferr, out_perr, out_data}, q[0]);
        end
        if (!rst && out_ready && q.size() != 0) void'(q.pop_front());
        if (ovr_clr) m_ovr = 0;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!clk16) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [4:0] c, input logic [7:0] d,
                              input bit pflip, input bit s0bad, input bit s1bad);
        int n;
        int nst;
        logic [7:0] dm;
        logic par;
        logic [9:0] entry;
        n = 5 + int'(c[1:0]);
        dm = d;
        for (int i = n; i < 8; i++) dm[i] = 1'b0;
        par = (c[2] ? ^dm : ~^dm) ^ pflip;
        entry = {s0bad | (c[4] & s1bad), c[3] & pflip, dm};
        nst = c[4] ? 2 : 1;
        cfg = c;
        rx = 1'b0;
        wait_ticks(16);
        cfg = 5'($urandom);
        for (int i = 0; i < n; i++) begin
            rx = dm[i];
            wait_ticks(16);
        end
        if (c[3]) begin
            rx = par;
            wait_ticks(16);
        end
        for (int s = 0; s < nst; s++) begin
            rx = (s == 0) ? !s0bad : !s1bad;
            if (s == nst - 1) begin
                wait_ticks(4);
                pending = 1;
                wait_ticks(12);
                if (q.size() < DEPTH) q.push_back(entry);
                else m_ovr = 1;
                pending = 0;
            end else begin
                wait_ticks(16);
            end
        end
        rx = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [9:0] exp);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check(name, {out_ferr, out_perr, out_data}, exp);
        force_rdy = 1;
        @(posedge clk); #3;
        force_rdy = 0;
        @(posedge clk); #3;
    endtask

    task automatic ovr_pulse();
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ticks(4);

        send_frame(5'b00011, 8'hA5, 0, 0, 0);
        wait_ticks(3);
        @(negedge clk);
        check("t1_count", fifo_count, 1);
        pop_check("t1_a5", 10'h0A5);

        send_frame(5'b01100, 8'h13, 1, 0, 0);
        wait_ticks(3);
        pop_check("t2_perr", 10'h113);

        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        check("t3_busy_hi", busy, 1);
        wait_ticks(14);
        @(negedge clk);
        check("t3_busy_lo", busy, 0);
        check("t3_count", fifo_count, 0);

        send_frame(5'b10011, 8'h3C, 0, 0, 1);
        wait_ticks(3);
        send_frame(5'b10011, 8'h55, 0, 0, 0);
        wait_ticks(3);
        pop_check("t4_ferr", 10'h23C);
        pop_check("t4_next", 10'h055);

        for (int i = 1; i <= 5; i++) begin
            send_frame(5'b00011, 8'(i), 0, 0, 0);
            wait_ticks(3);
        end
        @(negedge clk);
        check("t5_count", fifo_count, 4);
        check("t5_overrun", overrun, 1);
        for (int i = 1; i <= 4; i++) pop_check("t5_pop", 10'(i));
        ovr_pulse();
        @(negedge clk);
        check("t5_ovr_clr", overrun, 0);
        check("t5_empty", fifo_count, 0);

        cfg = 5'b00011;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            wait_ticks(16);
        end
        rx = 1'b1;
        rst = 1'b1;
        q.delete();
        m_ovr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(20);
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_count", fifo_count, 0);
        send_frame(5'b00011, 8'h42, 0, 0, 0);
        wait_ticks(3);
        pop_check("t6_42", 10'h042);

        for (int f = 0; f < 24; f++) begin
            rand_en = ($urandom_range(0, 1) == 1);
            send_frame(5'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            wait_ticks(2);
            if ($urandom_range(0, 4) == 0) ovr_pulse();
            wait_ticks($urandom_range(0, 10));
        end
        rand_en = 0;
        force_rdy = 1;
        begin
            int k = 0;
            while (q.size() != 0 && k < 200) begin
                @(posedge clk);
                k++;
            end
            check("drain_bound", k < 200, 1);
        end
        force_rdy = 0;
        repeat (4) @(negedge clk);
        check("final_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
